// File: rtl/pad_input_pkg.sv
// Shared constants and helpers for the pad input conditioner.
package pad_input_pkg;

   localparam int SYNC_STAGES         = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 16;

   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

   typedef logic [$clog2(DEBOUNCE_CYCLES_DEF + 1)-1:0] cnt_def_t;

endpackage

// File: rtl/pad_debounce_bit.sv
// One pad bit: synchroniser, debounce counter, stable level, edge pulses and sticky event flag.
module pad_debounce_bit
   import pad_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)
(
   input  logic clk,
   input  logic rst,
   input  logic pad_in,
   input  logic enable,
   input  logic clr_event,
   input  logic invert,
   output logic data_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic event_sticky
);

   localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   sticky_q, sticky_d;
   logic                   lvl;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], pad_in};
      lvl      = sync_q[SYNC_STAGES-1] ^ invert;
      cnt_d    = '0;
      stable_d = stable_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (enable && (lvl != stable_q)) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = lvl;
            rise_d   = lvl;
            fall_d   = ~lvl;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      // A pulse showing this cycle outranks a simultaneous clear.
      if (rise_q || fall_q) begin
         sticky_d = 1'b1;
      end else if (clr_event) begin
         sticky_d = 1'b0;
      end else begin
         sticky_d = sticky_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= invert;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         sticky_q <= sticky_d;
      end
   end

   assign data_out     = stable_q;
   assign rise_pulse   = rise_q;
   assign fall_pulse   = fall_q;
   assign event_sticky = sticky_q;

endmodule

// File: rtl/pad_input_conditioner.sv
// Conditions WIDTH asynchronous pad inputs into clean levels and single-cycle edge events.
// Optional PAD_INPUT_INVERT_EN adds a per-bit INVERT polarity port.
module pad_input_conditioner
   import pad_input_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)
(
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] PAD_IN,
   input  logic             ENABLE,
   input  logic [WIDTH-1:0] CLR_EVENT,
`ifdef PAD_INPUT_INVERT_EN
   input  logic [WIDTH-1:0] INVERT,
`endif
   output logic [WIDTH-1:0] DATA_OUT,
   output logic [WIDTH-1:0] RISE_PULSE,
   output logic [WIDTH-1:0] FALL_PULSE,
   output logic [WIDTH-1:0] EVENT_STICKY
);

   logic [WIDTH-1:0] invert_w;

`ifdef PAD_INPUT_INVERT_EN
   assign invert_w = INVERT;
`else
   assign invert_w = '0;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pad_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk          (CLK),
         .rst          (RESET),
         .pad_in       (PAD_IN[i]),
         .enable       (ENABLE),
         .clr_event    (CLR_EVENT[i]),
         .invert       (invert_w[i]),
         .data_out     (DATA_OUT[i]),
         .rise_pulse   (RISE_PULSE[i]),
         .fall_pulse   (FALL_PULSE[i]),
         .event_sticky (EVENT_STICKY[i])
      );
   end

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Scoreboard bench: a cycle-level behavioural model predicts every output vector; a monitor compares.
module tb_pad_input_conditioner;

   localparam int W = 4;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         RESET;
   logic [W-1:0] PAD_IN;
   logic         ENABLE;
   logic [W-1:0] CLR_EVENT;
   logic [W-1:0] DATA_OUT, RISE_PULSE, FALL_PULSE, EVENT_STICKY;
`ifdef PAD_INPUT_INVERT_EN
   logic [W-1:0] INVERT;
`endif

   always #5 clk = ~clk;

   pad_input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .CLK          (clk),
      .RESET        (RESET),
      .PAD_IN       (PAD_IN),
      .ENABLE       (ENABLE),
      .CLR_EVENT    (CLR_EVENT),
`ifdef PAD_INPUT_INVERT_EN
      .INVERT       (INVERT),
`endif
      .DATA_OUT     (DATA_OUT),
      .RISE_PULSE   (RISE_PULSE),
      .FALL_PULSE   (FALL_PULSE),
      .EVENT_STICKY (EVENT_STICKY)
   );

   typedef struct packed {
      logic [W-1:0] d;
      logic [W-1:0] r;
      logic [W-1:0] f;
      logic [W-1:0] s;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   bit   started     = 1'b0;
   bit   done        = 1'b0;
   int   cyc_no      = 0;

   // Stimulus state
   logic [W-1:0] cur_pad = '0;
   logic         cur_en  = 1'b1;
   logic [W-1:0] cur_clr = '0;
   logic [W-1:0] cur_inv = '0;

   // Reference model: pad values seen at the last two edges, accepted level,
   // consecutive disagreeing enabled edges, and the visible outputs.
   logic [W-1:0] pad_seen[2];
   logic [W-1:0] m_stable = '0, m_rise = '0, m_fall = '0, m_sticky = '0;
   int           m_run[W];

   task automatic model_edge(input bit r, input logic [W-1:0] pad, input logic en,
                             input logic [W-1:0] clr, input logic [W-1:0] inv);
      logic [W-1:0] nr, nf, ns;
      logic         lvl;
      if (r) begin
         pad_seen[0] = '0;
         pad_seen[1] = '0;
         m_stable    = inv;
         m_rise      = '0;
         m_fall      = '0;
         m_sticky    = '0;
         for (int i = 0; i < W; i++) m_run[i] = 0;
         return;
      end
      nr = '0;
      nf = '0;
      for (int i = 0; i < W; i++) begin
         ns[i] = (m_rise[i] | m_fall[i]) ? 1'b1 : (clr[i] ? 1'b0 : m_sticky[i]);
         lvl = pad_seen[1][i] ^ inv[i];
         if (en && (lvl != m_stable[i])) begin
            m_run[i]++;
            if (m_run[i] == D) begin
               m_stable[i] = lvl;
               nr[i]       = lvl;
               nf[i]       = ~lvl;
               m_run[i]    = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_rise      = nr;
      m_fall      = nf;
      m_sticky    = ns;
      pad_seen[1] = pad_seen[0];
      pad_seen[0] = pad;
   endtask

   task automatic cyc(input bit r);
      exp_t e;
      @(negedge clk);
      RESET     = r;
      PAD_IN    = cur_pad;
      ENABLE    = cur_en;
      CLR_EVENT = cur_clr;
`ifdef PAD_INPUT_INVERT_EN
      INVERT    = cur_inv;
`endif
      model_edge(r, cur_pad, cur_en, cur_clr, cur_inv);
      e.d = m_stable;
      e.r = m_rise;
      e.f = m_fall;
      e.s = m_sticky;
      exp_q.push_back(e);
      started = 1'b1;
   endtask

   // Monitor: every edge after stimulus starts presents one output vector.
   initial begin
      exp_t e, got;
      forever begin
         @(posedge clk);
         #1;
         cyc_no++;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{DATA_OUT, RISE_PULSE, FALL_PULSE, EVENT_STICKY};
            vectors++;
            if (got !== e) begin
               miscompares++;
               $display("FAIL outputs cycle %0d: got d=%b r=%b f=%b s=%b, want d=%b r=%b f=%b s=%b",
                        cyc_no, got.d, got.r, got.f, got.s, e.d, e.r, e.f, e.s);
            end
         end else if (started && !done) begin
            miscompares++;
            $display("FAIL scoreboard cycle %0d: DUT output with no expected entry", cyc_no);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1; PAD_IN = '0; ENABLE = 1'b1; CLR_EVENT = '0;
`ifdef PAD_INPUT_INVERT_EN
      INVERT = '0;
      cur_inv = 4'b1000;
`endif
      for (int i = 0; i < W; i++) m_run[i] = 0;
      pad_seen[0] = '0;
      pad_seen[1] = '0;

      repeat (3) cyc(1'b1);
      repeat (4) cyc(1'b0);

      // Clean rising edge on bit 0
      cur_pad[0] = 1'b1;
      repeat (10) cyc(1'b0);

      // Bounce on bit 1: never D consecutive matching samples
      for (int k = 0; k < 5; k++) begin
         cur_pad[1] = 1'b1; repeat (3) cyc(1'b0);
         cur_pad[1] = 1'b0; cyc(1'b0);
      end
      repeat (6) cyc(1'b0);

      // Clear coincident with a falling pulse on bit 0, then a lone clear
      cur_pad[0] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cur_clr[0] = m_fall[0];
         cyc(1'b0);
      end
      cur_clr = '0;
      repeat (3) cyc(1'b0);
      cur_clr[0] = 1'b1; cyc(1'b0);
      cur_clr = '0;
      repeat (3) cyc(1'b0);

      // Freeze, then re-enable
      cur_en = 1'b0; cur_pad[2] = 1'b1;
      repeat (20) cyc(1'b0);
      cur_en = 1'b1;
      repeat (8) cyc(1'b0);

      // Reset part-way through a debounce count
      cur_pad[3] = 1'b1;
      repeat (4) cyc(1'b0);
      cyc(1'b1);
      repeat (10) cyc(1'b0);

      // Randomised traffic
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < W; i++)
            if ($urandom_range(5) == 0) cur_pad[i] = ~cur_pad[i];
         cur_en  = ($urandom_range(9) != 0);
         cur_clr = ($urandom_range(3) == 0) ? W'($urandom) : '0;
`ifdef PAD_INPUT_INVERT_EN
         if ($urandom_range(49) == 0) cur_inv[$urandom_range(W-1)] ^= 1'b1;
`endif
         cyc($urandom_range(99) == 0);
      end
      cur_clr = '0;
      repeat (12) cyc(1'b0);

      @(posedge clk);
      #2;
      done = 1'b1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
